// File: rtl/ddr_arbiter_pkg.sv
// Shared widths, state encoding and command record for the DDR arbiter.
package ddr_arbiter_pkg;
    localparam int ADDR_W               = 24;
    localparam int DATA_W               = 16;
    localparam int REFRESH_INTERVAL_DEF = 1000;

    typedef enum logic [1:0] {ST_IDLE, ST_REFRESH, ST_VID, ST_GFX} arb_state_t;

    localparam logic GRANT_VID = 1'b0;
    localparam logic GRANT_GFX = 1'b1;

    // Latched copy of the granted client request; the Ddr side only ever sees this.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ddr_cmd_t;
endpackage

// File: rtl/ddr_arbiter_refresh_timer.sv
// Refresh interval down-counter with a pending request flag and a sticky overrun flag.
module refresh_timer
    import ddr_arbiter_pkg::*;
#(
    parameter int INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic pending,
    output logic overrun
);
    localparam int            CW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cnt <= expire ? RELOAD : cnt - 1'b1;
            // Expiry beats a completing refresh; it is only an overrun if the old one is still owed.
            if (expire)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
            if (expire && pending && !clear)
                overrun <= 1'b1;
        end
    end
endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates display reads, graphics reads/writes and periodic refresh onto one Ddr port.
module ddr_arbiter
    import ddr_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic              vidReq,
    input  logic [ADDR_W-1:0] vidAddress,
    output logic              vidAck,
    output logic [DATA_W-1:0] vidData,
    input  logic              gfxReq,
    input  logic              gfxWrite,
    input  logic [ADDR_W-1:0] gfxAddress,
    input  logic [DATA_W-1:0] gfxWriteData,
    output logic              gfxAck,
    output logic [DATA_W-1:0] gfxReadData,
    output logic              read,
    output logic [ADDR_W-1:0] readAddress,
    input  logic              readAcknowledge,
    input  logic [DATA_W-1:0] readData,
    output logic              write,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic              writeAcknowledge,
    output logic              refresh,
    input  logic              refreshAcknowledge,
    output logic              refreshOverrun
);
    arb_state_t state;
    ddr_cmd_t   cmd;
    logic       last_grant;
    logic       refresh_pending;
    logic       refresh_done;
    logic       ack_busy;

    assign refresh_done = (state == ST_REFRESH) && refreshAcknowledge;
    assign ack_busy     = vidAck || gfxAck;

    refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh_timer (
        .clk     (clk133_p),
        .rst     (rst),
        .clear   (refresh_done),
        .pending (refresh_pending),
        .overrun (refreshOverrun)
    );

    assign readAddress  = cmd.addr;
    assign writeAddress = cmd.addr;
    assign writeData    = cmd.data;

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            last_grant  <= GRANT_GFX;
            read        <= 1'b0;
            write       <= 1'b0;
            refresh     <= 1'b0;
            vidAck      <= 1'b0;
            gfxAck      <= 1'b0;
            vidData     <= '0;
            gfxReadData <= '0;
        end else begin
            vidAck <= 1'b0;
            gfxAck <= 1'b0;
            case (state)
                // Hold off while an ack pulses so a still-asserted request is not re-served.
                ST_IDLE: if (!ack_busy) begin
                    if (refresh_pending) begin
                        state   <= ST_REFRESH;
                        refresh <= 1'b1;
                    end else if (vidReq && (!gfxReq || last_grant == GRANT_GFX)) begin
                        state      <= ST_VID;
                        read       <= 1'b1;
                        last_grant <= GRANT_VID;
                        cmd.wr     <= 1'b0;
                        cmd.addr   <= vidAddress;
                    end else if (gfxReq) begin
                        state      <= ST_GFX;
                        read       <= !gfxWrite;
                        write      <= gfxWrite;
                        last_grant <= GRANT_GFX;
                        cmd.wr     <= gfxWrite;
                        cmd.addr   <= gfxAddress;
                        cmd.data   <= gfxWriteData;
                    end
                end
                ST_REFRESH: if (refreshAcknowledge) begin
                    refresh <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_VID: if (readAcknowledge) begin
                    read    <= 1'b0;
                    vidAck  <= 1'b1;
                    vidData <= readData;
                    state   <= ST_IDLE;
                end
                ST_GFX: if (cmd.wr ? writeAcknowledge : readAcknowledge) begin
                    read   <= 1'b0;
                    write  <= 1'b0;
                    gfxAck <= 1'b1;
                    if (!cmd.wr)
                        gfxReadData <= readData;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Randomised bench for ddr_arbiter: Ddr memory responder, transaction-level scoreboard, directed scenarios.
module tb_ddr_arbiter;
    import ddr_arbiter_pkg::*;

    localparam int RI = 16;

    logic        clk133_p = 1'b0;
    logic        rst = 1'b1;
    logic        vidReq = 1'b0;
    logic [23:0] vidAddress = '0;
    logic        vidAck;
    logic [15:0] vidData;
    logic        gfxReq = 1'b0, gfxWrite = 1'b0;
    logic [23:0] gfxAddress = '0;
    logic [15:0] gfxWriteData = '0;
    logic        gfxAck;
    logic [15:0] gfxReadData;
    logic        read, write, refresh, refreshOverrun;
    logic [23:0] readAddress, writeAddress;
    logic [15:0] writeData;
    logic        readAcknowledge = 1'b0, writeAcknowledge = 1'b0, refreshAcknowledge = 1'b0;
    logic [15:0] readData = '0;

    always #5 clk133_p = ~clk133_p;

    ddr_arbiter #(.REFRESH_INTERVAL(RI)) dut (
        .clk133_p(clk133_p), .rst(rst),
        .vidReq(vidReq), .vidAddress(vidAddress), .vidAck(vidAck), .vidData(vidData),
        .gfxReq(gfxReq), .gfxWrite(gfxWrite), .gfxAddress(gfxAddress),
        .gfxWriteData(gfxWriteData), .gfxAck(gfxAck), .gfxReadData(gfxReadData),
        .read(read), .readAddress(readAddress), .readAcknowledge(readAcknowledge), .readData(readData),
        .write(write), .writeAddress(writeAddress), .writeData(writeData),
        .writeAcknowledge(writeAcknowledge),
        .refresh(refresh), .refreshAcknowledge(refreshAcknowledge), .refreshOverrun(refreshOverrun)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ddr memory: untouched words read back as a fixed function of the address.
    logic [15:0] mem [logic [23:0]];
    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'hC3A5);
    endfunction

    int max_dly = 3, fixed_dly = -1;
    bit spurious = 0;
    int rd_cnt = 0, wr_cnt = 0, rf_cnt = 0;

    function automatic int pick_dly();
        return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(max_dly, 0));
    endfunction

    // Ddr responder: acks each request after a delay; optional stray acks on idle ports.
    always begin : ddr_model
        @(negedge clk133_p); #1;
        readAcknowledge = 0; writeAcknowledge = 0; refreshAcknowledge = 0;
        readData = 16'($urandom);
        if (rst) begin
            rd_cnt = 0; wr_cnt = 0; rf_cnt = 0;
        end else begin
            if (read) begin
                if (rd_cnt == 0) begin readAcknowledge = 1; readData = mem_rd(readAddress); end
                else rd_cnt--;
            end else begin
                rd_cnt = pick_dly();
                readAcknowledge = spurious && ($urandom_range(5, 0) == 0);
            end
            if (write) begin
                if (wr_cnt == 0) begin writeAcknowledge = 1; mem[writeAddress] = writeData; end
                else wr_cnt--;
            end else begin
                wr_cnt = pick_dly();
                writeAcknowledge = spurious && ($urandom_range(5, 0) == 0);
            end
            if (refresh) begin
                if (rf_cnt == 0) refreshAcknowledge = 1;
                else rf_cnt--;
            end else begin
                rf_cnt = pick_dly();
                refreshAcknowledge = spurious && ($urandom_range(5, 0) == 0);
            end
        end
    end

    // Outstanding client transactions as the clients intend them.
    logic [23:0] vid_tx_addr = '0, gfx_tx_addr = '0;
    logic [15:0] gfx_tx_data = '0;
    logic        gfx_tx_wr = 1'b0;

    int  n_edge = 0, pend_wait = 0, n_rd_rise = 0;
    bit  m_pend = 0, m_ovr = 0;
    int  vid_wait_gfx = 0, gfx_wait_vid = 0;
    logic        p_read = 0, p_write = 0, p_refresh = 0;
    logic [23:0] p_raddr = '0, p_waddr = '0;
    logic [15:0] p_wdata = '0;
    int ack_log[$];
    int ref_rise_log[$];

    // Scoreboard: judges each clock edge from the inputs held across it and outputs before/after.
    always @(negedge clk133_p) begin : mon
        bit expire, clear, done_rd, done_wr;
        if (rst) begin
            n_edge = 0; m_pend = 0; m_ovr = 0; pend_wait = 0;
            vid_wait_gfx = 0; gfx_wait_vid = 0;
            p_read = 0; p_write = 0; p_refresh = 0;
        end else begin
            n_edge++;
            expire = (n_edge % RI) == 0;
            clear  = p_refresh && refreshAcknowledge;
            if (refresh && !p_refresh) begin
                chk("refresh_without_pending", m_pend, 1);
                ref_rise_log.push_back(n_edge);
            end
            if (read && !p_read) n_rd_rise++;
            if (expire && m_pend && !clear) m_ovr = 1;
            m_pend = expire ? 1'b1 : (clear ? 1'b0 : m_pend);
            chk("overrun", refreshOverrun, m_ovr);
            chk("onehot_req", $countones({read, write, refresh}) <= 1, 1);
            pend_wait = (m_pend && !refresh) ? pend_wait + 1 : 0;
            chk("refresh_latency", pend_wait <= 12, 1);

            done_rd = p_read && readAcknowledge;
            done_wr = p_write && writeAcknowledge;
            chk("ack_vs_completion", int'(vidAck) + int'(gfxAck), int'(done_rd || done_wr));
            if (done_rd || done_wr) chk("req_drop", {read, write}, 0);
            if (vidAck) begin
                chk("vid_kind", done_rd, 1);
                chk("vid_addr", p_raddr, vid_tx_addr);
                chk("vid_data", vidData, mem_rd(vid_tx_addr));
                ack_log.push_back(0);
            end
            if (gfxAck) begin
                if (gfx_tx_wr) begin
                    chk("gfx_wr_kind", done_wr, 1);
                    chk("gfx_wr_addr", p_waddr, gfx_tx_addr);
                    chk("gfx_wr_data", p_wdata, gfx_tx_data);
                end else begin
                    chk("gfx_rd_kind", done_rd, 1);
                    chk("gfx_rd_addr", p_raddr, gfx_tx_addr);
                    chk("gfx_rd_data", gfxReadData, mem_rd(gfx_tx_addr));
                end
                ack_log.push_back(1);
            end
            // A waiting client may see at most one transaction of the other client.
            if (!vidReq || vidAck) vid_wait_gfx = 0; else if (gfxAck) vid_wait_gfx++;
            if (!gfxReq || gfxAck) gfx_wait_vid = 0; else if (vidAck) gfx_wait_vid++;
            if (vidAck || gfxAck) chk("starvation", vid_wait_gfx <= 1 && gfx_wait_vid <= 1, 1);

            p_read = read; p_write = write; p_refresh = refresh;
            p_raddr = readAddress; p_waddr = writeAddress; p_wdata = writeData;
        end
    end

    task automatic tick();
        @(negedge clk133_p); #1;
    endtask

    // One cycle of client behaviour: retire on ack, then maybe start a new request.
    task automatic clients(input int pct, input bit keep);
        if (vidReq && vidAck) vidReq = 0;
        if (gfxReq && gfxAck) gfxReq = 0;
        if (!vidReq && (keep || $urandom_range(99, 0) < pct)) begin
            vid_tx_addr = 24'($urandom);
            vidAddress  = vid_tx_addr;
            vidReq      = 1;
        end
        if (!gfxReq && (keep || $urandom_range(99, 0) < pct)) begin
            gfx_tx_addr = 24'($urandom);
            gfx_tx_data = 16'($urandom);
            gfx_tx_wr   = 1'($urandom_range(1, 0));
            gfxAddress = gfx_tx_addr; gfxWriteData = gfx_tx_data; gfxWrite = gfx_tx_wr;
            gfxReq = 1;
        end
    endtask

    function automatic logic sig_val(input int sel);
        case (sel)
            0: return read;
            1: return write;
            2: return refresh;
            3: return vidAck;
            default: return gfxAck;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, input string tag);
        int k = 0;
        while (!sig_val(sel) && k < budget) begin tick(); k++; end
        chk(tag, sig_val(sel), 1);
    endtask

    task automatic drain();
        int k = 0;
        while ((vidReq || gfxReq) && k < 100) begin tick(); clients(0, 0); k++; end
        chk("drain", {vidReq, gfxReq}, 0);
    endtask

    initial begin
        int rr0;
        tick(); tick();
        chk("rst_ctl", {read, write, refresh, vidAck, gfxAck, refreshOverrun}, 0);
        chk("rst_data", {vidData, gfxReadData}, 0);
        rst = 0;

        // Single display read; address pin scrambled mid-flight must not leak through.
        mem[24'h000123] = 16'hBEEF;
        vid_tx_addr = 24'h000123; vidAddress = vid_tx_addr; vidReq = 1;
        wait_sig(0, 40, "t_vid_read_issued");
        chk("t_vid_raddr", readAddress, 24'h000123);
        vidAddress = 24'h000000;
        tick();
        chk("t_vid_raddr_held", readAddress, 24'h000123);
        wait_sig(3, 40, "t_vid_ack");
        chk("t_vid_data", vidData, 16'hBEEF);
        vidReq = 0;
        tick();
        chk("t_vid_ack_pulse", vidAck, 0);

        // Graphics write to the top of the lower half; no read may appear.
        rr0 = n_rd_rise;
        gfx_tx_addr = 24'h7FFFFF; gfx_tx_data = 16'hA5A5; gfx_tx_wr = 1;
        gfxAddress = gfx_tx_addr; gfxWriteData = gfx_tx_data; gfxWrite = 1; gfxReq = 1;
        wait_sig(1, 40, "t_gfx_write_issued");
        chk("t_gfx_waddr", writeAddress, 24'h7FFFFF);
        chk("t_gfx_wdata", writeData, 16'hA5A5);
        wait_sig(4, 40, "t_gfx_ack");
        gfxReq = 0;
        chk("t_gfx_no_read", n_rd_rise, rr0);
        chk("t_gfx_mem", mem_rd(24'h7FFFFF), 16'hA5A5);

        // Idle: refresh exactly every RI cycles, no overrun.
        max_dly = 0;
        ref_rise_log.delete();
        repeat (70) tick();
        chk("t_idle_refresh_count", ref_rise_log.size() >= 4, 1);
        for (int i = 1; i < ref_rise_log.size(); i++)
            chk("t_idle_refresh_period", ref_rise_log[i] - ref_rise_log[i-1], RI);
        chk("t_idle_overrun", refreshOverrun, 0);

        // Both clients held continuously: grants alternate, starting with vid.
        max_dly = 3;
        ack_log.delete();
        for (int k = 0; k < 400 && ack_log.size() < 8; k++) begin clients(0, 1); tick(); end
        chk("t_rr_acks", ack_log.size() >= 8, 1);
        if (ack_log.size() > 0) chk("t_rr_first", ack_log[0], 0);
        for (int i = 1; i < ack_log.size(); i++)
            chk("t_rr_alternate", ack_log[i] != ack_log[i-1], 1);
        drain();

        // Random traffic with stray acks on idle ports.
        spurious = 1;
        for (int k = 0; k < 600; k++) begin clients(30, 0); tick(); end
        spurious = 0;
        drain();
        chk("t_rand_no_overrun", refreshOverrun, 0);

        // Refresh ack withheld past one interval: sticky overrun, no double refresh.
        fixed_dly = 20;
        repeat (60) tick();
        chk("t_ovr_set", refreshOverrun, 1);
        begin
            int k = 0;
            while (refresh && k < 40) begin tick(); k++; end
        end
        chk("t_ovr_refresh_done", refresh, 0);
        repeat (3) begin tick(); chk("t_ovr_single_refresh", refresh, 0); end

        // Reset in the middle of a write drops it without a clock edge.
        fixed_dly = 6;
        gfx_tx_addr = 24'h00BEEF; gfx_tx_data = 16'h1234; gfx_tx_wr = 1;
        gfxAddress = gfx_tx_addr; gfxWriteData = gfx_tx_data; gfxWrite = 1; gfxReq = 1;
        wait_sig(1, 40, "t_rst_write_issued");
        #1 rst = 1;
        #1;
        chk("t_rst_async_write", write, 0);
        chk("t_rst_ctl", {read, write, refresh, vidAck, gfxAck, refreshOverrun}, 0);
        chk("t_rst_data", {vidData, gfxReadData}, 0);
        gfxReq = 0; vidReq = 0;
        tick(); tick();
        rst = 0;
        fixed_dly = -1;
        ack_log.delete();
        for (int k = 0; k < 100 && ack_log.size() < 2; k++) begin clients(0, 1); tick(); end
        chk("t_rst_two_acks", ack_log.size() >= 2, 1);
        if (ack_log.size() >= 2) begin
            chk("t_rst_first_tie_vid", ack_log[0], 0);
            chk("t_rst_second_gfx", ack_log[1], 1);
        end
        drain();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
